ampl_detector_win: RTL and testbench
====================================

Name: ampl_detector_win

Overview:
Parametrised sliding-window amplitude detector for the receiver front end.
- Estimates per-sample I/Q magnitude and averages it over a 2^LOG2N-sample window; the accumulator advances only on valid samples.
- Derives scaled decision thresholds (general and 8PSK) from the mean.
- Runs a hysteresis carrier-detect FSM with confirm and hang timers.
- Feeds the demodulator decision logic and the AGC/squelch.

Parameters:
- W, 16: I/Q sample width (signed).
- LOG2N, 6: log2 of window length N.
- CW, 20: threshold coefficient width, unsigned, FRAC=CW-2 fractional bits.
- CONFIRM, 4: consecutive above-hi means needed to declare carrier.
- HOLD, 64: hang length in valid samples after the mean drops below lo.

Ports:
- clk, in, 1: clock.
- reset_b, in, 1: reset, synchronous, active-low.
- restart, in, 1: synchronous flush of window, fill counter and FSM; config registers kept.
- in_valid, in, 1: sample strobe.
- sig_i, in, W: I sample (signed).
- sig_q, in, W: Q sample (signed).
- thresh_noise, in, W+2: additive noise floor (unsigned).
- thresh_coeff, in, CW: mean scale factor.
- squelch_hi, in, W: carrier on level.
- squelch_lo, in, W: carrier off level.
- ampl_out, out, W: window mean magnitude.
- ampl_valid, out, 1: window full.
- thresh, out, W+2: general decision threshold.
- thresh_8psk, out, W+2: 8PSK decision threshold.
- carrier, out, 1: carrier detected.
- state, out, 3: FSM state, for debug.

Behaviour:
- Reset (reset_b=0 at clk edge): all registers 0, except the coefficient register = 2^FRAC (1.0). All outputs 0; state = IDLE.
- Magnitude, in mag_est, latency 2 valid-aligned cycles:
  - Stage 1: |x| with -2^(W-1) saturated to 2^(W-1)-1.
  - Stage 2: mag = max + (min>>1), unsigned W bits; it cannot overflow.
- Window:
  - Magnitude delay line of depth N, advanced only on mag_valid.
  - fill counter 0..N.
  - On mag_valid: acc <= acc + mag - (full ? mag_del : 0); acc is W+LOG2N bits.
  - Delay line contents are don't-care until full, so no clear is required.
- ampl_out = acc[W+LOG2N-1:LOG2N] (truncating mean).
- ampl_valid is registered; it rises on the cycle the N-th sample is accumulated.
- Config: thresh_noise and thresh_coeff are registered every cycle (1-cycle latency).
- Thresholds, 2-stage pipeline after the acc update:
  - prod <= ampl_out * coeff_r.
  - base = prod >> FRAC.
  - thresh <= sat(base + noise_r).
  - thresh_8psk <= sat(base + (noise_r>>3)).
  - sat clamps to 2^(W+2)-1.
  - Thresholds update every cycle regardless of valid.
- FSM, evaluated only on cycles where acc updated, using the new mean. cnt counts evaluated samples.
  - IDLE: go to SEARCH when ampl_valid.
  - SEARCH: if mean >= hi, go to ACQ with cnt=1 (if CONFIRM=1, go straight to LOCK).
  - ACQ: mean >= hi increments cnt; cnt==CONFIRM goes to LOCK. mean < hi returns to SEARCH with cnt=0.
  - LOCK: mean < lo goes to HANG with cnt=0.
  - HANG: mean >= hi returns to LOCK. Otherwise cnt increments; cnt==HOLD goes to SEARCH.
    - Means between lo and hi keep counting.
  - carrier=1 in LOCK and HANG, registered with the state.
  - If squelch_lo > squelch_hi, hi wins on entry and lo governs exit; no error.
- restart:
  - Clears acc, fill, ampl_valid, FSM (to IDLE), carrier and the mag_est valid pipe.
  - Takes priority over a simultaneous in_valid; that sample is discarded.
  - Thresholds decay to noise_r via the pipeline.
- Reset mid-operation behaves identically to restart plus config reset.
- State encoding: IDLE=0, SEARCH=1, ACQ=2, LOCK=3, HANG=4.

Decomposition:
- Shared include/package ampl_det_pkg:
  - state encoding constants.
  - FRAC derivation.
  - saturation-width helper.
- Sub-module mag_est (params W): 2-stage abs/max/min magnitude with valid pipe, synchronous active-low reset.
- Window, threshold and FSM stay in the top block.

Test Plan:
All scenarios use W=16, LOG2N=3, CW=20, CONFIRM=4, HOLD=16.
1. Continuous valid, I=1000, Q=0, coeff=262144, noise=200 -> ampl_valid rises with the 8th sample; ampl_out=1000; thresh=1200 and thresh_8psk=1025 two cycles later.
2. I=Q=-32768 continuous -> mag=49150; ampl_out=49150; thresh with noise=0 and coeff=2^19 (2.0) = 98300; no overflow.
3. in_valid on every 3rd cycle, I=600, Q=800 -> mag=1100; ampl_out reaches 1100 after 8 strobes; acc is unchanged on non-valid cycles.
4. hi=500, lo=400; mean steps 0 -> 1000 -> carrier rises on the 4th full-window mean >=500. Then input 0:
   - carrier holds 16 evaluated samples after mean <400, then drops to SEARCH.
   - A mean of 450 during HANG does not relock.
5. In LOCK, assert restart together with in_valid -> next cycle acc=0, ampl_valid=0, carrier=0, state=IDLE; the refill takes a fresh 8 samples.
6. reset_b low for one cycle mid-stream -> all outputs 0 next cycle and coeff=2^18; then behaviour is as in scenario 1.

Source files
------------

// File: rtl/ampl_det_pkg.sv
// Shared definitions for the sliding-window amplitude detector: FSM encoding
// and width helpers used by the top and its magnitude sub-block.
package ampl_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_ACQ    = 3'd2,
        ST_LOCK   = 3'd3,
        ST_HANG   = 3'd4
    } state_t;

    // Coefficients are unsigned fixed point with two integer bits.
    function automatic int frac_bits(input int cw);
        return cw - 2;
    endfunction

    // Thresholds carry two guard bits above the sample width before clamping.
    function automatic int thr_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/ampl_detector_win_if.sv
// Sample stream into the detector. in_valid is a plain strobe with no
// back-pressure: every cycle with in_valid high delivers one I/Q pair.
interface ampl_detector_win_if #(parameter int W = 16) ();
    logic                in_valid;
    logic signed [W-1:0] sig_i;
    logic signed [W-1:0] sig_q;

    modport master (output in_valid, sig_i, sig_q);
    modport slave  (input  in_valid, sig_i, sig_q);
endinterface

// File: rtl/ampl_detector_win_mag_est.sv
// Two-stage I/Q magnitude estimate: saturating abs, then max + min/2.
// restart drops any samples still in flight.
module mag_est #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                restart,
    input  logic                in_valid,
    input  logic signed [W-1:0] sig_i,
    input  logic signed [W-1:0] sig_q,
    output logic [W-1:0]        mag,
    output logic                mag_valid
);

    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        else if (x[W-1])
            return -x;
        else
            return x;
    endfunction

    logic [W-1:0] abs_i_q, abs_q_q;
    logic         v1_q;
    logic [W-1:0] mx, mn;

    assign mx = (abs_i_q >= abs_q_q) ? abs_i_q : abs_q_q;
    assign mn = (abs_i_q >= abs_q_q) ? abs_q_q : abs_i_q;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            abs_i_q   <= '0;
            abs_q_q   <= '0;
            v1_q      <= 1'b0;
            mag       <= '0;
            mag_valid <= 1'b0;
        end else if (restart) begin
            v1_q      <= 1'b0;
            mag_valid <= 1'b0;
        end else begin
            v1_q      <= in_valid;
            mag_valid <= v1_q;
            if (in_valid) begin
                abs_i_q <= abs_sat(sig_i);
                abs_q_q <= abs_sat(sig_q);
            end
            // Both inputs are at most 2^(W-1)-1, so the sum fits in W bits.
            if (v1_q)
                mag <= mx + (mn >> 1);
        end
    end

endmodule

// File: rtl/ampl_detector_win.sv
// Sliding-window mean magnitude with scaled decision thresholds and a
// hysteresis carrier-detect FSM (confirm and hang timers).
module ampl_detector_win
    import ampl_det_pkg::*;
#(
    parameter int W       = 16,
    parameter int LOG2N   = 6,
    parameter int CW      = 20,
    parameter int CONFIRM = 4,
    parameter int HOLD    = 64
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                restart,
    ampl_detector_win_if.slave  smp,
    input  logic [W+1:0]        thresh_noise,
    input  logic [CW-1:0]       thresh_coeff,
    input  logic [W-1:0]        squelch_hi,
    input  logic [W-1:0]        squelch_lo,
    output logic [W-1:0]        ampl_out,
    output logic                ampl_valid,
    output logic [W+1:0]        thresh,
    output logic [W+1:0]        thresh_8psk,
    output logic                carrier,
    output logic [2:0]          state
);

    localparam int FRAC    = frac_bits(CW);
    localparam int TW      = thr_width(W);
    localparam int N       = 1 << LOG2N;
    localparam int ACCW    = W + LOG2N;
    localparam int CNT_MAX = (HOLD > CONFIRM) ? HOLD : CONFIRM;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] COEFF_ONE = CW'(1) << FRAC;

    logic [W-1:0] mag;
    logic         mag_valid;

    mag_est #(.W(W)) u_mag_est (
        .clk       (clk),
        .reset_b   (reset_b),
        .restart   (restart),
        .in_valid  (smp.in_valid),
        .sig_i     (smp.sig_i),
        .sig_q     (smp.sig_q),
        .mag       (mag),
        .mag_valid (mag_valid)
    );

    // Window: circular delay line plus running sum.
    logic [W-1:0]     line_q [N];
    logic [LOG2N-1:0] wr_ptr_q;
    logic [LOG2N:0]   fill_q;
    logic [ACCW-1:0]  acc_q, acc_next;
    logic             full, full_next, upd;
    logic [W-1:0]     mag_del, mean_next;

    assign upd       = mag_valid && !restart;
    assign full      = (fill_q == (LOG2N+1)'(N));
    assign full_next = full || (fill_q == (LOG2N+1)'(N - 1));
    assign mag_del   = line_q[wr_ptr_q];
    assign acc_next  = acc_q + ACCW'(mag) - (full ? ACCW'(mag_del) : '0);
    assign mean_next = acc_next[ACCW-1:LOG2N];
    assign ampl_out  = acc_q[ACCW-1:LOG2N];

    // Stale contents are never read before being overwritten, so no clear.
    always_ff @(posedge clk) begin
        if (upd)
            line_q[wr_ptr_q] <= mag;
    end

    always_ff @(posedge clk) begin
        if (!reset_b || restart) begin
            acc_q      <= '0;
            fill_q     <= '0;
            wr_ptr_q   <= '0;
            ampl_valid <= 1'b0;
        end else if (upd) begin
            acc_q      <= acc_next;
            wr_ptr_q   <= wr_ptr_q + LOG2N'(1);
            ampl_valid <= full_next;
            if (!full)
                fill_q <= fill_q + (LOG2N+1)'(1);
        end
    end

    // Thresholds: registered config, product, then saturating add.
    logic [CW-1:0]   coeff_r;
    logic [TW-1:0]   noise_r, base;
    logic [W+CW-1:0] prod_q;

    function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TW] ? '1 : s[TW-1:0];
    endfunction

    assign base = prod_q[FRAC +: TW];

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            noise_r     <= '0;
            coeff_r     <= COEFF_ONE;
            prod_q      <= '0;
            thresh      <= '0;
            thresh_8psk <= '0;
        end else begin
            noise_r     <= thresh_noise;
            coeff_r     <= thresh_coeff;
            prod_q      <= {{CW{1'b0}}, ampl_out} * {{W{1'b0}}, coeff_r};
            thresh      <= sat_add(base, noise_r);
            thresh_8psk <= sat_add(base, noise_r >> 3);
        end
    end

    // Carrier-detect FSM, stepped only when a new mean is produced.
    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            above_hi, below_lo;

    assign above_hi = (mean_next >= squelch_hi);
    assign below_lo = (mean_next <  squelch_lo);
    assign cnt_inc  = cnt_q + CNTW'(1);

    always_ff @(posedge clk) begin
        if (!reset_b || restart) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (upd) begin
            case (state_q)
                ST_IDLE: begin
                    if (full_next) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end
                end
                ST_SEARCH: begin
                    if (above_hi) begin
                        if (CONFIRM == 1) begin
                            state_d = ST_LOCK;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ACQ;
                            cnt_d   = CNTW'(1);
                        end
                    end
                end
                ST_ACQ: begin
                    if (!above_hi) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNTW'(CONFIRM)) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                ST_LOCK: begin
                    if (below_lo) begin
                        state_d = ST_HANG;
                        cnt_d   = '0;
                    end
                end
                ST_HANG: begin
                    // Means between lo and hi keep the hang timer running.
                    if (above_hi) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNTW'(HOLD)) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        carrier = (state_q == ST_LOCK) || (state_q == ST_HANG);
        state   = state_q;
    end

endmodule

// File: tb/tb_ampl_detector_win.sv
// Directed bench for ampl_detector_win (W=16, LOG2N=3, CW=20, CONFIRM=4, HOLD=16).
module tb_ampl_detector_win;
    import ampl_det_pkg::*;

    logic        clk;
    logic        reset_b;
    logic        restart;
    logic [17:0] thresh_noise;
    logic [19:0] thresh_coeff;
    logic [15:0] squelch_hi;
    logic [15:0] squelch_lo;
    logic [15:0] ampl_out;
    logic        ampl_valid;
    logic [17:0] thresh;
    logic [17:0] thresh_8psk;
    logic        carrier;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    ampl_detector_win_if #(.W(16)) smp ();

    ampl_detector_win #(
        .W(16), .LOG2N(3), .CW(20), .CONFIRM(4), .HOLD(16)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .restart      (restart),
        .smp          (smp),
        .thresh_noise (thresh_noise),
        .thresh_coeff (thresh_coeff),
        .squelch_hi   (squelch_hi),
        .squelch_lo   (squelch_lo),
        .ampl_out     (ampl_out),
        .ampl_valid   (ampl_valid),
        .thresh       (thresh),
        .thresh_8psk  (thresh_8psk),
        .carrier      (carrier),
        .state        (state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic signed [15:0] i, input logic signed [15:0] q);
        smp.in_valid = 1'b1;
        smp.sig_i    = i;
        smp.sig_q    = q;
        @(negedge clk);
        smp.in_valid = 1'b0;
    endtask

    task automatic push_n(input logic signed [15:0] i, input logic signed [15:0] q, input int n);
        for (int k = 0; k < n; k++) push(i, q);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ampl_out"},   ampl_out,    0);
        check({tag, "_ampl_valid"}, ampl_valid,  0);
        check({tag, "_thresh"},     thresh,      0);
        check({tag, "_thresh8"},    thresh_8psk, 0);
        check({tag, "_carrier"},    carrier,     0);
        check({tag, "_state"},      state,       ST_IDLE);
    endtask

    initial begin
        reset_b      = 1'b0;
        restart      = 1'b0;
        smp.in_valid = 1'b0;
        smp.sig_i    = '0;
        smp.sig_q    = '0;
        thresh_noise = 18'd200;
        thresh_coeff = 20'd262144;
        squelch_hi   = 16'd500;
        squelch_lo   = 16'd400;
        tick(2);
        check_all_zero("reset");
        reset_b = 1'b1;
        tick(2);

        // 1: continuous 1000, coeff 1.0, noise 200
        push_n(16'sd1000, 16'sd0, 7);
        tick(2);
        check("t1_valid_7", ampl_valid, 0);
        check("t1_mean_7",  ampl_out,   875);
        push(16'sd1000, 16'sd0);
        tick(2);
        check("t1_valid_8",  ampl_valid, 1);
        check("t1_mean_8",   ampl_out,   1000);
        check("t1_thr_old",  thresh,     1075);
        tick(2);
        check("t1_thresh",   thresh,      1200);
        check("t1_thresh8",  thresh_8psk, 1025);

        // 2: full-scale negative I and Q, coeff 2.0, noise 0
        thresh_coeff = 20'd524288;
        thresh_noise = 18'd0;
        do_restart();
        push_n(-16'sd32768, -16'sd32768, 8);
        tick(4);
        check("t2_mean",    ampl_out,    49150);
        check("t2_valid",   ampl_valid,  1);
        check("t2_thresh",  thresh,      98300);
        check("t2_thresh8", thresh_8psk, 98300);

        // 3: strobe every third cycle, I=600 Q=800
        thresh_coeff = 20'd262144;
        thresh_noise = 18'd200;
        do_restart();
        for (int k = 0; k < 7; k++) begin
            push(16'sd600, 16'sd800);
            tick(2);
        end
        check("t3_mean_7",  ampl_out,   962);
        check("t3_valid_7", ampl_valid, 0);
        tick(3);
        check("t3_hold",    ampl_out,   962);
        push(16'sd600, 16'sd800);
        tick(2);
        check("t3_mean_8",  ampl_out,   1100);
        check("t3_valid_8", ampl_valid, 1);
        tick(2);
        check("t3_thresh",  thresh,      1300);
        check("t3_thresh8", thresh_8psk, 1125);

        // 4: carrier acquire, lock, hang and release
        do_restart();
        push_n(16'sd0, 16'sd0, 8);
        tick(2);
        check("t4_search", state,   ST_SEARCH);
        check("t4_car0",   carrier, 0);
        push_n(16'sd1000, 16'sd0, 6);
        tick(2);
        check("t4_acq",    state,   ST_ACQ);
        check("t4_car1",   carrier, 0);
        push(16'sd1000, 16'sd0);
        tick(2);
        check("t4_lock",   state,   ST_LOCK);
        check("t4_car2",   carrier, 1);
        push(16'sd1000, 16'sd0);
        push_n(16'sd0, 16'sd0, 4);
        tick(2);
        check("t4_lock500", state,  ST_LOCK);
        push(16'sd0, 16'sd0);
        tick(2);
        check("t4_mean375", ampl_out, 375);
        check("t4_hang",    state,    ST_HANG);
        check("t4_car3",    carrier,  1);
        push(16'sd1600, 16'sd0);
        tick(2);
        check("t4_mean450", ampl_out, 450);
        check("t4_norelock", state,   ST_HANG);
        push_n(16'sd0, 16'sd0, 14);
        tick(2);
        check("t4_hang15",  state,   ST_HANG);
        check("t4_car4",    carrier, 1);
        push(16'sd0, 16'sd0);
        tick(2);
        check("t4_release", state,   ST_SEARCH);
        check("t4_car5",    carrier, 0);

        // 5: restart with a simultaneous sample while locked
        push_n(16'sd1000, 16'sd0, 8);
        tick(2);
        check("t5_lock", state, ST_LOCK);
        restart      = 1'b1;
        smp.in_valid = 1'b1;
        smp.sig_i    = 16'sd1000;
        smp.sig_q    = 16'sd0;
        @(negedge clk);
        restart      = 1'b0;
        smp.in_valid = 1'b0;
        check("t5_mean",    ampl_out,   0);
        check("t5_valid",   ampl_valid, 0);
        check("t5_carrier", carrier,    0);
        check("t5_state",   state,      ST_IDLE);
        tick(3);
        check("t5_discard", ampl_out,   0);
        push_n(16'sd1000, 16'sd0, 7);
        tick(2);
        check("t5_valid_7", ampl_valid, 0);
        check("t5_mean_7",  ampl_out,   875);
        push(16'sd1000, 16'sd0);
        tick(2);
        check("t5_valid_8", ampl_valid, 1);
        check("t5_mean_8",  ampl_out,   1000);
        check("t5_search",  state,      ST_SEARCH);

        // 6: one-cycle reset mid-stream
        push_n(16'sd1000, 16'sd0, 3);
        reset_b      = 1'b0;
        smp.in_valid = 1'b1;
        @(negedge clk);
        reset_b      = 1'b1;
        smp.in_valid = 1'b0;
        check_all_zero("t6_reset");
        tick(3);
        check("t6_flushed", ampl_out, 0);
        push_n(16'sd1000, 16'sd0, 8);
        tick(2);
        check("t6_valid",   ampl_valid, 1);
        check("t6_mean",    ampl_out,   1000);
        tick(2);
        check("t6_thresh",  thresh,      1200);
        check("t6_thresh8", thresh_8psk, 1025);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
